// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: sequences LOAD then SHIFT cycles on a shift register.
// Accepts one request at a time; abort and async reset return to IDLE.
module shift_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_load_i,
  input  logic             req_dir_i,
  input  logic [CW-1:0]    req_count_i,
  input  logic [WIDTH-1:0] req_word_i,
  input  logic             abort_i,
  output logic [1:0]       funct_o,
  output logic [WIDTH-1:0] word_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [1:0] F_NA    = 2'b00;
  localparam logic [1:0] F_LOAD  = 2'b01;
  localparam logic [1:0] F_LEFT  = 2'b10;
  localparam logic [1:0] F_RIGHT = 2'b11;

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  state_t           state_q, state_d;
  logic             load_q, load_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             idle;
  logic             accept;
  logic [CW-1:0]    cnt_sat;

  assign idle    = (state_q == S_IDLE);
  assign accept  = req_valid_i & idle & ~abort_i;
  assign cnt_sat = (req_count_i > CNT_MAX) ? CNT_MAX : req_count_i;

  // State and captured-request registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      load_q  <= 1'b0;
      dir_q   <= 1'b0;
      word_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      dir_q   <= dir_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: capture on accept, count down in SHIFT, abort wins
  always_comb begin
    state_d = state_q;
    load_d  = load_q;
    dir_d   = dir_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          load_d = req_load_i;
          dir_d  = req_dir_i;
          cnt_d  = cnt_sat;
          if (req_load_i) begin
            word_d = req_word_i;
          end
          if (req_load_i) begin
            state_d = S_LOAD;
          end else if (cnt_sat != '0) begin
            state_d = S_SHIFT;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_LOAD: begin
        state_d = (cnt_q != '0) ? S_SHIFT : S_DONE;
      end
      S_SHIFT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (abort_i && !idle) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  // Moore outputs, with abort masking function and done in the same cycle
  always_comb begin
    funct_o     = F_NA;
    done_o      = 1'b0;
    req_ready_o = idle;
    busy_o      = ~idle;
    word_o      = word_q;
    unique case (state_q)
      S_LOAD:  funct_o = F_LOAD;
      S_SHIFT: funct_o = dir_q ? F_RIGHT : F_LEFT;
      S_DONE:  done_o  = 1'b1;
      default: funct_o = F_NA;
    endcase
    if (abort_i) begin
      funct_o = F_NA;
      done_o  = 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: per-cycle vector table plus latency and
// mid-cycle async reset sequences for shift_seq_ctrl (WIDTH=4).
module tb_shift_seq_ctrl;

  localparam int WIDTH = 4;
  localparam int CW    = 3;

  logic             clk;
  logic             rst;
  logic             req_valid_i;
  logic             req_ready_o;
  logic             req_load_i;
  logic             req_dir_i;
  logic [CW-1:0]    req_count_i;
  logic [WIDTH-1:0] req_word_i;
  logic             abort_i;
  logic [1:0]       funct_o;
  logic [WIDTH-1:0] word_o;
  logic             busy_o;
  logic             done_o;

  shift_seq_ctrl #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_load_i  (req_load_i),
    .req_dir_i   (req_dir_i),
    .req_count_i (req_count_i),
    .req_word_i  (req_word_i),
    .abort_i     (abort_i),
    .funct_o     (funct_o),
    .word_o      (word_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected: {ready, funct[1:0], word[3:0], busy, done}
  typedef struct {
    logic       r;
    logic       va;
    logic       ld;
    logic       dr;
    logic [2:0] c;
    logic [3:0] w;
    logic       ab;
    logic [8:0] exp;
  } vec_t;

  vec_t vq[$];
  int   total;
  int   bad;

  function automatic vec_t mk(
    input logic r, input logic va, input logic ld,
    input logic dr, input logic [2:0] c, input logic [3:0] w,
    input logic ab, input logic rdy, input logic [1:0] f,
    input logic [3:0] wo, input logic b, input logic d);
    vec_t v;
    v.r   = r;
    v.va  = va;
    v.ld  = ld;
    v.dr  = dr;
    v.c   = c;
    v.w   = w;
    v.ab  = ab;
    v.exp = {rdy, f, wo, b, d};
    return v;
  endfunction

  function automatic logic [8:0] outs();
    return {req_ready_o, funct_o, word_o, busy_o, done_o};
  endfunction

  task automatic chk(input string nm, input logic [8:0] got,
                     input logic [8:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b (rdy,funct,word,busy,done)",
               nm, got, exp);
    end
  endtask

  task automatic chk1(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, exp);
    end
  endtask

  task automatic idle_in();
    req_valid_i = 1'b0;
    req_load_i  = 1'b0;
    req_dir_i   = 1'b0;
    req_count_i = '0;
    req_word_i  = '0;
    abort_i     = 1'b0;
  endtask

  // Issue a request and count cycles from the accept edge to done_o
  task automatic run_latency(input logic ld, input logic dr,
                             input logic [2:0] c, input logic [3:0] w,
                             input int exp_lat, input string nm);
    int lat;
    int busy_cnt;
    @(negedge clk);
    req_valid_i = 1'b1;
    req_load_i  = ld;
    req_dir_i   = dr;
    req_count_i = c;
    req_word_i  = w;
    lat      = 0;
    busy_cnt = 0;
    do begin
      @(negedge clk);
      idle_in();
      #1;
      lat++;
      if (busy_o) busy_cnt++;
    end while (!done_o && lat < 20);
    chk1({nm, "_lat"}, lat, exp_lat);
    chk1({nm, "_busy"}, busy_cnt, exp_lat);
  endtask

  initial begin
    int dseen;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    idle_in();

    // reset, including a request presented while in reset
    vq.push_back(mk(1,0,0,0,0,4'h0,0, 1,2'b00,4'h0,0,0));
    vq.push_back(mk(1,1,1,0,3,4'hF,0, 1,2'b00,4'h0,0,0));
    vq.push_back(mk(0,0,0,0,0,4'h0,0, 1,2'b00,4'h0,0,0));
    // load + left 3
    vq.push_back(mk(0,1,1,0,3,4'hB,0, 1,2'b00,4'h0,0,0));
    vq.push_back(mk(0,0,0,0,0,4'h0,0, 0,2'b01,4'hB,1,0));
    vq.push_back(mk(0,0,0,0,0,4'h0,0, 0,2'b10,4'hB,1,0));
    vq.push_back(mk(0,0,0,0,0,4'h0,0, 0,2'b10,4'hB,1,0));
    vq.push_back(mk(0,0,0,0,0,4'h0,0, 0,2'b10,4'hB,1,0));
    vq.push_back(mk(0,0,0,0,0,4'h0,0, 0,2'b00,4'hB,1,1));
    vq.push_back(mk(0,0,0,0,0,4'h0,0, 1,2'b00,4'hB,0,0));
    // right 2, no load: word must not change
    vq.push_back(mk(0,1,0,1,2,4'h5,0, 1,2'b00,4'hB,0,0));
    vq.push_back(mk(0,0,0,0,0,4'h0,0, 0,2'b11,4'hB,1,0));
    vq.push_back(mk(0,0,0,0,0,4'h0,0, 0,2'b11,4'hB,1,0));
    vq.push_back(mk(0,0,0,0,0,4'h0,0, 0,2'b00,4'hB,1,1));
    vq.push_back(mk(0,0,0,0,0,4'h0,0, 1,2'b00,4'hB,0,0));
    // degenerate: no load, count 0
    vq.push_back(mk(0,1,0,1,0,4'h3,0, 1,2'b00,4'hB,0,0));
    vq.push_back(mk(0,0,0,0,0,4'h0,0, 0,2'b00,4'hB,1,1));
    vq.push_back(mk(0,0,0,0,0,4'h0,0, 1,2'b00,4'hB,0,0));
    // saturation: count 7 -> 4 shifts
    vq.push_back(mk(0,1,0,0,7,4'h0,0, 1,2'b00,4'hB,0,0));
    vq.push_back(mk(0,0,0,0,0,4'h0,0, 0,2'b10,4'hB,1,0));
    vq.push_back(mk(0,0,0,0,0,4'h0,0, 0,2'b10,4'hB,1,0));
    vq.push_back(mk(0,0,0,0,0,4'h0,0, 0,2'b10,4'hB,1,0));
    vq.push_back(mk(0,0,0,0,0,4'h0,0, 0,2'b10,4'hB,1,0));
    vq.push_back(mk(0,0,0,0,0,4'h0,0, 0,2'b00,4'hB,1,1));
    vq.push_back(mk(0,0,0,0,0,4'h0,0, 1,2'b00,4'hB,0,0));
    // abort in IDLE blocks accept
    vq.push_back(mk(0,1,1,0,1,4'h6,1, 1,2'b00,4'hB,0,0));
    vq.push_back(mk(0,0,0,0,0,4'h0,0, 1,2'b00,4'hB,0,0));
    // abort on 2nd SHIFT of count 4, valid held high throughout
    vq.push_back(mk(0,1,0,1,4,4'h0,0, 1,2'b00,4'hB,0,0));
    vq.push_back(mk(0,1,1,0,1,4'h7,0, 0,2'b11,4'hB,1,0));
    vq.push_back(mk(0,1,1,0,1,4'h7,1, 0,2'b00,4'hB,1,0));
    vq.push_back(mk(0,1,1,0,1,4'h9,0, 1,2'b00,4'hB,0,0));
    vq.push_back(mk(0,1,0,1,3,4'h2,0, 0,2'b01,4'h9,1,0));
    vq.push_back(mk(0,1,0,1,3,4'h2,0, 0,2'b10,4'h9,1,0));
    vq.push_back(mk(0,0,0,0,0,4'h0,0, 0,2'b00,4'h9,1,1));
    vq.push_back(mk(0,0,0,0,0,4'h0,0, 1,2'b00,4'h9,0,0));
    // abort in DONE suppresses done_o
    vq.push_back(mk(0,1,0,0,0,4'h0,0, 1,2'b00,4'h9,0,0));
    vq.push_back(mk(0,0,0,0,0,4'h0,1, 0,2'b00,4'h9,1,0));
    vq.push_back(mk(0,0,0,0,0,4'h0,0, 1,2'b00,4'h9,0,0));
    // abort in LOAD
    vq.push_back(mk(0,1,1,0,2,4'hA,0, 1,2'b00,4'h9,0,0));
    vq.push_back(mk(0,0,0,0,0,4'h0,1, 0,2'b00,4'hA,1,0));
    vq.push_back(mk(0,0,0,0,0,4'h0,0, 1,2'b00,4'hA,0,0));
    // reset during SHIFT, accept right after release
    vq.push_back(mk(0,1,0,0,4,4'h0,0, 1,2'b00,4'hA,0,0));
    vq.push_back(mk(0,0,0,0,0,4'h0,0, 0,2'b10,4'hA,1,0));
    vq.push_back(mk(0,0,0,0,0,4'h0,0, 0,2'b10,4'hA,1,0));
    vq.push_back(mk(1,0,0,0,0,4'h0,0, 1,2'b00,4'h0,0,0));
    vq.push_back(mk(0,1,0,1,1,4'h0,0, 1,2'b00,4'h0,0,0));
    vq.push_back(mk(0,0,0,0,0,4'h0,0, 0,2'b11,4'h0,1,0));
    vq.push_back(mk(0,0,0,0,0,4'h0,0, 0,2'b00,4'h0,1,1));
    vq.push_back(mk(0,0,0,0,0,4'h0,0, 1,2'b00,4'h0,0,0));

    foreach (vq[i]) begin
      @(negedge clk);
      rst         = vq[i].r;
      req_valid_i = vq[i].va;
      req_load_i  = vq[i].ld;
      req_dir_i   = vq[i].dr;
      req_count_i = vq[i].c;
      req_word_i  = vq[i].w;
      abort_i     = vq[i].ab;
      #1;
      chk($sformatf("vec%0d", i), outs(), vq[i].exp);
    end

    // full-latency measurements
    run_latency(1'b1, 1'b0, 3'd3, 4'hB, 5, "ld_l3");
    run_latency(1'b0, 1'b1, 3'd2, 4'h0, 3, "r2");
    run_latency(1'b0, 1'b0, 3'd7, 4'h0, 5, "sat7");

    // reset asserted mid-cycle during SHIFT
    @(negedge clk);
    idle_in();
    req_valid_i = 1'b1;
    req_count_i = 3'd4;
    @(negedge clk);
    idle_in();
    @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", outs(), {1'b1, 2'b00, 4'h0, 1'b0, 1'b0});
    dseen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done_o) dseen++;
    end
    chk1("rst_no_done", dseen, 0);
    rst = 1'b0;
    run_latency(1'b1, 1'b1, 3'd2, 4'hC, 4, "post_rst");
    chk("post_rst_word", outs(), {1'b0, 2'b00, 4'hC, 1'b1, 1'b1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 4: data width of the controlled shift register; WIDTH >= 2.
REQ-002 Parameter CW, default $clog2(WIDTH+1): width of the shift-count field.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_valid_i  input  1  request present; qualified by req_ready_o.
REQ-006 req_ready_o  output  1  controller idle and able to accept a request.
REQ-007 req_load_i  input  1  request includes a parallel load before shifting.
REQ-008 req_dir_i  input  1  shift direction: 0 = left, 1 = right.
REQ-009 req_count_i  input  CW  number of shift cycles requested.
REQ-010 req_word_i  input  WIDTH  word to load when req_load_i = 1.
REQ-011 abort_i  input  1  cancel the current operation.
REQ-012 funct_o  output  2  shift-register function: 00 NA, 01 LOAD, 10 LEFT, 11 RIGHT.
REQ-013 word_o  output  WIDTH  captured load word, driven to the shift register word input.
REQ-014 busy_o  output  1  high in any state other than IDLE.
REQ-015 done_o  output  1  one-cycle pulse on normal completion.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, LOAD, SHIFT and DONE. All outputs are Moore decodes of the state and captured registers.
REQ-017 In IDLE: req_ready_o = 1, funct_o = 00, busy_o = 0, done_o = 0.
REQ-018 Accept occurs on a posedge with req_valid_i & req_ready_o & !abort_i. It captures load, dir, word and count; a count greater than WIDTH saturates to WIDTH.
REQ-019 Next state after accept:
- LOAD if load = 1;
- else SHIFT if count > 0;
- else DONE.
REQ-020 LOAD lasts exactly one cycle with funct_o = 01 and word_o = captured word. It then goes to SHIFT if count > 0, else to DONE.
REQ-021 SHIFT drives funct_o = 10 (dir 0) or 11 (dir 1). The remaining count decrements once per SHIFT cycle. SHIFT exits to DONE after the cycle in which the remaining count is 1, so SHIFT lasts exactly count cycles.
REQ-022 DONE lasts exactly one cycle with funct_o = 00 and done_o = 1, then returns to IDLE.
REQ-023 Latency from accept edge to the done_o cycle SHALL be (load ? 1 : 0) + count + 1 cycles.
REQ-024 req_valid_i outside IDLE SHALL be ignored; no queuing.
REQ-025 A request is accepted in the cycle immediately after DONE at the earliest; there are no back-to-back accepts without the IDLE cycle.
REQ-026 abort_i = 1 in LOAD, SHIFT or DONE:
- funct_o forced to 00 combinationally in that cycle;
- done_o forced to 0;
- next state IDLE;
- remaining count cleared.
REQ-027 abort_i = 1 in IDLE SHALL block the accept, and the state remains IDLE.
REQ-028 word_o SHALL hold the last captured word; it changes only on accept with load = 1.
REQ-029 funct_o SHALL never equal 01 outside the LOAD state, and never equal 10 or 11 outside the SHIFT state.

Reset
REQ-030 While rst is high, the block SHALL be in IDLE with every register cleared: count, dir, load and word_o = 0.
REQ-031 While rst is high, outputs SHALL be: req_ready_o = 1, busy_o = 0, done_o = 0, funct_o = 00.
REQ-032 Reset asserted mid-operation SHALL take effect immediately and asynchronously, with no done_o pulse. The first accept is possible on the first posedge after rst deasserts.

Verification
REQ-033 The bench SHALL cover, with WIDTH = 4, the following scenarios:
- Load + left 3: req load=1, dir=0, count=3, word=4'b1011 -> funct_o 01, 10, 10, 10, 00. word_o=1011 during LOAD. done_o on cycle 5 after accept; busy_o high for 5 cycles.
- Right, no load, count=2 -> funct_o 11, 11, then DONE with done_o=1, then IDLE with req_ready_o=1.
- Degenerate request load=0, count=0 -> DONE in the cycle after accept; no LEFT, RIGHT or LOAD ever driven.
- Saturation: count=7 with CW=3 -> exactly 4 SHIFT cycles, then done_o.
- Abort: abort_i on the 2nd SHIFT cycle of a count=4 request -> funct_o=00 that cycle, IDLE next cycle, no done_o. A req_valid_i held high during busy is not accepted until IDLE.
- Async reset during SHIFT (count=4, after 2 shifts) -> immediate funct_o=00 and busy_o=0, no done_o. A new request after release completes with full latency.
